// File: rtl/pc_sequencer.sv
// pc_sequencer: three-state program counter sequencer with increment, stall,
// relative branch and table-driven absolute branch, plus a writable target table.
module pc_sequencer #(
    parameter int D = 10,
    parameter int N = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 halt_req,
    input  logic                 stall,
    input  logic                 abs_jump,
    input  logic                 rel_jump,
    input  logic                 taken,
    input  logic [$clog2(N)-1:0] lut_idx,
    input  logic [D-1:0]         rel_off,
    input  logic                 tbl_we,
    input  logic [$clog2(N)-1:0] tbl_waddr,
    input  logic [D-1:0]         tbl_wdata,
    output logic [D-1:0]         pc,
    output logic                 running,
    output logic                 done,
    output logic                 tbl_err
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t         state_q, state_d;
    logic [D-1:0]   pc_q, pc_d;
    logic           tbl_err_q, tbl_err_d;
    logic [D-1:0]   tbl_q [N];
    logic [D-1:0]   tbl_d [N];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        tbl_err_d = 1'b0;
        tbl_d     = tbl_q;
        case (state_q)
            IDLE: begin
                pc_d = '0;
                if (start) state_d = RUN;
            end
            RUN: begin
                if (halt_req)              state_d = HALT;
                else if (stall)            pc_d = pc_q;
                else if (abs_jump && taken) pc_d = tbl_q[lut_idx];
                else if (rel_jump && taken) pc_d = pc_q + rel_off;
                else                       pc_d = pc_q + D'(1);
            end
            HALT: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
            end
        endcase
        // the table is frozen while running; a write attempt there is flagged instead
        if (tbl_we) begin
            if (state_q == RUN) tbl_err_d = 1'b1;
            else                tbl_d[tbl_waddr] = tbl_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            tbl_err_q <= 1'b0;
            for (int i = 0; i < N; i++) tbl_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            tbl_err_q <= tbl_err_d;
            tbl_q     <= tbl_d;
        end
    end

    assign pc      = pc_q;
    assign tbl_err = tbl_err_q;
    assign running = (state_q == RUN);
    assign done    = (state_q == HALT);
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random stimulus; a reference model queues the
// expected post-edge outputs and a monitor compares them each cycle.
module tb_pc_sequencer;
    localparam int D   = 10;
    localparam int MOD = 1 << D;
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

    logic         clk = 0, reset_n = 0, start = 0, halt_req = 0, stall = 0;
    logic         abs_jump = 0, rel_jump = 0, taken = 0, tbl_we = 0;
    logic [3:0]   lut_idx = 0, tbl_waddr = 0;
    logic [D-1:0] rel_off = 0, tbl_wdata = 0;
    logic [D-1:0] pc;
    logic         running, done, tbl_err;

    pc_sequencer #(.D(D), .N(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .halt_req(halt_req),
        .stall(stall), .abs_jump(abs_jump), .rel_jump(rel_jump), .taken(taken),
        .lut_idx(lut_idx), .rel_off(rel_off), .tbl_we(tbl_we),
        .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata), .pc(pc),
        .running(running), .done(done), .tbl_err(tbl_err)
    );

    always #5 clk = ~clk;

    typedef struct { int pc; bit run; bit dn; bit err; } exp_t;
    exp_t q[$];
    int checks = 0, failures = 0;
    int m_mode = M_IDLE, m_pc = 0;
    bit m_err = 0;
    int m_tbl [16];

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", n, act, exp, $time);
        end
    endtask

    // drive one cycle's inputs at the falling edge and queue the model's view of the next edge
    task automatic tick(input logic st = 0, input logic hr = 0, input logic stl = 0,
                        input logic aj = 0, input logic rj = 0, input logic tk = 0,
                        input logic [3:0] li = 0, input logic [D-1:0] ro = 0,
                        input logic we = 0, input logic [3:0] wa = 0,
                        input logic [D-1:0] wd = 0, input logic rn = 1);
        int off;
        exp_t e;
        @(negedge clk);
        reset_n = rn; start = st; halt_req = hr; stall = stl; abs_jump = aj;
        rel_jump = rj; taken = tk; lut_idx = li; rel_off = ro; tbl_we = we;
        tbl_waddr = wa; tbl_wdata = wd;
        if (!rn) begin
            m_mode = M_IDLE; m_pc = 0; m_err = 0;
            foreach (m_tbl[i]) m_tbl[i] = 0;
        end else begin
            m_err = we && (m_mode == M_RUN);
            if (we && m_mode != M_RUN) m_tbl[wa] = wd;
            if (m_mode == M_RUN) begin
                off = (int'(ro) >= MOD / 2) ? int'(ro) - MOD : int'(ro);
                if (hr) m_mode = M_HALT;
                else if (stl) m_pc = m_pc;
                else if (aj && tk) m_pc = m_tbl[li];
                else if (rj && tk) m_pc = (m_pc + off + MOD) % MOD;
                else m_pc = (m_pc + 1) % MOD;
            end else if (st) begin
                m_mode = M_RUN;
                m_pc = 0;
            end
        end
        e.pc = m_pc; e.run = (m_mode == M_RUN); e.dn = (m_mode == M_HALT); e.err = m_err;
        q.push_back(e);
    endtask

    task automatic after_edge(input string n, input int exp);
        @(posedge clk);
        #2;
        chk(n, pc, exp);
    endtask

    task automatic run_to(input int t);
        tick(.rj(1), .tk(1), .ro(D'(t - m_pc)));
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc", pc, e.pc);
            chk("running", running, e.run);
            chk("done", done, e.dn);
            chk("tbl_err", tbl_err, e.err);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (m_tbl[i]) m_tbl[i] = 0;
        #1;
        chk("reset_pc", pc, 0);
        chk("reset_running", running, 0);
        chk("reset_done", done, 0);
        chk("reset_tbl_err", tbl_err, 0);
        tick(.rn(0));
        tick(.we(1), .wa(3), .wd(68));
        tick(.st(1));
        for (int i = 1; i <= 3; i++) tick();
        tick(); tick();
        tick(.aj(1), .tk(1), .li(3));
        after_edge("abs_taken", 68);
        run_to(5);
        tick(.aj(1), .tk(0), .li(3));
        after_edge("abs_not_taken", 6);
        run_to(20);
        tick(.rj(1), .tk(1), .ro(10'h3FB));
        after_edge("rel_neg", 15);
        run_to(1020);
        tick(.rj(1), .tk(1), .ro(20));
        after_edge("rel_wrap", 16);
        run_to(1023);
        tick();
        after_edge("inc_wrap", 0);
        run_to(7);
        for (int i = 0; i < 3; i++) begin
            tick(.stl(1));
            after_edge("stall", 7);
        end
        tick(.stl(1), .hr(1));
        after_edge("halt_pc", 7);
        chk("halt_done", done, 1);
        tick(.st(1));
        after_edge("restart_pc", 0);
        chk("restart_running", running, 1);
        tick(.st(1));
        after_edge("start_in_run", 1);
        tick(.we(1), .wa(3), .wd(99));
        @(posedge clk); #2;
        chk("tbl_err_pulse", tbl_err, 1);
        tick();
        @(posedge clk); #2;
        chk("tbl_err_clear", tbl_err, 0);
        tick(.aj(1), .rj(1), .tk(1), .li(3), .ro(5));
        after_edge("abs_after_reject", 68);
        tick(.hr(1));
        tick(.st(1), .we(1), .wa(5), .wd(123));
        tick(.aj(1), .tk(1), .li(5));
        after_edge("halt_write_start", 123);
        run_to(40);
        @(posedge clk);
        #3;
        reset_n = 0;
        m_mode = M_IDLE; m_pc = 0; m_err = 0;
        foreach (m_tbl[i]) m_tbl[i] = 0;
        #1;
        chk("async_reset_pc", pc, 0);
        chk("async_reset_running", running, 0);
        tick(.rn(0));
        tick(.st(1));
        tick(.aj(1), .tk(1), .li(3));
        after_edge("abs_after_reset", 0);
        for (int i = 0; i < 3000; i++) begin
            tick(.st($urandom_range(7) == 0), .hr($urandom_range(31) == 0),
                 .stl($urandom_range(7) == 0), .aj($urandom_range(3) == 0),
                 .rj($urandom_range(3) == 0), .tk($urandom_range(1) == 1),
                 .li(4'($urandom)), .ro(D'($urandom)),
                 .we($urandom_range(7) == 0), .wa(4'($urandom)), .wd(D'($urandom)),
                 .rn($urandom_range(199) != 0));
        end
        repeat (3) @(posedge clk);
        #3;
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
